// File: rtl/multireg4bit_checker_pkg.sv
// Shared types, widths and helpers for the 4-bit multi-mode register checker.
package multireg4bit_checker_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned CNT_W  = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SYNC   = 2'b01,
    ST_CHECK  = 2'b10,
    ST_FAILED = 2'b11
  } state_t;

  typedef enum logic [MODE_W-1:0] {
    MODE_LOAD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_ROTL = 2'b11
  } mode_t;

  // Snapshot of the register-under-test control and data inputs.
  typedef struct packed {
    logic              hold;
    logic              rst;
    logic              set;
    mode_t             mode;
    logic [DATA_W-1:0] data;
  } ctrl_t;

  // Saturating increment: counters stick at their maximum.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/multireg4bit_model.sv
// Reference model of the register under test: predicted value plus a Known flag
// telling whether the prediction is fully determined by observed inputs.
module multireg4bit_model
  import multireg4bit_checker_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_known,
  input  ctrl_t             ctrl,
  output logic [DATA_W-1:0] value,
  output logic              known,
  output logic              known_nxt_c
);

  logic [DATA_W-1:0] mode_val;
  logic [DATA_W-1:0] value_nxt;
  logic              sync_evt;

  always_comb begin
    mode_val = value;
    unique case (ctrl.mode)
      MODE_LOAD: mode_val = ctrl.data;
      MODE_SHL:  mode_val = {value[DATA_W-2:0], 1'b0};
      MODE_SHR:  mode_val = {1'b0, value[DATA_W-1:1]};
      MODE_ROTL: mode_val = {value[DATA_W-2:0], value[DATA_W-1]};
    endcase
  end

  // Priority: clear > set > hold > mode operation.
  always_comb begin
    value_nxt = value;
    if (ctrl.rst) begin
      value_nxt = '0;
    end else if (ctrl.set) begin
      value_nxt = '1;
    end else if (!ctrl.hold) begin
      value_nxt = mode_val;
    end
  end

  // Any of these fully determines the register contents regardless of history.
  assign sync_evt    = ctrl.rst | ctrl.set | (~ctrl.hold & (ctrl.mode == MODE_LOAD));
  assign known_nxt_c = ~clr_known & (known | sync_evt);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      known <= 1'b0;
    end else begin
      value <= value_nxt;
      known <= known_nxt_c;
    end
  end

endmodule

// File: rtl/multireg4bit_checker.sv
// Cycle-accurate checker for a 4-bit multi-mode register: tracks the expected
// value, compares the observed output one cycle after each update and counts errors.
module multireg4bit_checker
  import multireg4bit_checker_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Arm,
  input  logic              DutHold,
  input  logic              DutRst,
  input  logic              DutSet,
  input  logic [MODE_W-1:0] DutS,
  input  logic [DATA_W-1:0] DutX,
  input  logic [DATA_W-1:0] DutY,
  output logic              Err,
  output logic              Fail,
  output logic [CNT_W-1:0]  ErrCnt,
  output logic [CNT_W-1:0]  ChkCnt,
  output logic [DATA_W-1:0] Expected,
  output logic [1:0]        State
);

  ctrl_t             ctrl;
  logic [DATA_W-1:0] exp_val;
  logic              known;
  logic              known_nxt_c;

  state_t            state;
  state_t            state_nxt;
  logic              err_nxt;
  logic              fail_nxt;
  logic [CNT_W-1:0]  err_cnt_nxt;
  logic [CNT_W-1:0]  chk_cnt_nxt;
  logic              cmp_c;
  logic              mismatch_c;

  assign ctrl = '{hold: DutHold, rst: DutRst, set: DutSet, mode: mode_t'(DutS), data: DutX};

  multireg4bit_model u_model (
    .clk         (Clk),
    .rst         (Rst),
    .clr_known   (~Arm),
    .ctrl        (ctrl),
    .value       (exp_val),
    .known       (known),
    .known_nxt_c (known_nxt_c)
  );

  // Compare against the pre-edge prediction only while armed and synchronised.
  assign cmp_c      = Arm & known & ((state == ST_CHECK) | (state == ST_FAILED));
  assign mismatch_c = cmp_c & (DutY != exp_val);

  always_comb begin
    state_nxt   = state;
    err_nxt     = 1'b0;
    fail_nxt    = Fail;
    err_cnt_nxt = ErrCnt;
    chk_cnt_nxt = ChkCnt;

    if (cmp_c) begin
      chk_cnt_nxt = sat_inc(ChkCnt);
    end
    if (mismatch_c) begin
      err_nxt     = 1'b1;
      fail_nxt    = 1'b1;
      err_cnt_nxt = sat_inc(ErrCnt);
    end

    if (!Arm) begin
      state_nxt = ST_IDLE;
      fail_nxt  = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE:   state_nxt = ST_SYNC;
        ST_SYNC:   if (known_nxt_c) state_nxt = ST_CHECK;
        ST_CHECK:  if (mismatch_c) state_nxt = ST_FAILED;
        ST_FAILED: state_nxt = ST_FAILED;
      endcase
    end
  end

  // Reset discards any comparison in flight on the same edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= ST_IDLE;
      Err    <= 1'b0;
      Fail   <= 1'b0;
      ErrCnt <= '0;
      ChkCnt <= '0;
    end else begin
      state  <= state_nxt;
      Err    <= err_nxt;
      Fail   <= fail_nxt;
      ErrCnt <= err_cnt_nxt;
      ChkCnt <= chk_cnt_nxt;
    end
  end

  assign State    = state;
  assign Expected = exp_val;

endmodule

// File: tb/tb_multireg4bit_checker.sv
// Randomised and directed bench for multireg4bit_checker against a behavioural model.
module tb_multireg4bit_checker;

  logic       Clk = 1'b0;
  logic       Rst, Arm, DutHold, DutRst, DutSet;
  logic [1:0] DutS;
  logic [3:0] DutX, DutY;
  logic       Err, Fail;
  logic [7:0] ErrCnt, ChkCnt;
  logic [3:0] Expected;
  logic [1:0] State;

  multireg4bit_checker dut (
    .Clk(Clk), .Rst(Rst), .Arm(Arm), .DutHold(DutHold), .DutRst(DutRst),
    .DutSet(DutSet), .DutS(DutS), .DutX(DutX), .DutY(DutY), .Err(Err),
    .Fail(Fail), .ErrCnt(ErrCnt), .ChkCnt(ChkCnt), .Expected(Expected),
    .State(State)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural reference: state numbers 0 idle, 1 sync, 2 check, 3 failed.
  int m_state = 0, m_exp = 0, m_known = 0, m_err = 0, m_fail = 0, m_ecnt = 0, m_ccnt = 0;
  int reg_y = 0;  // ideal register under test, never touched by checker reset

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int next_reg(input int cur, input bit r, input bit s, input bit h,
                                  input int mode, input int x);
    if (r) return 0;
    if (s) return 15;
    if (h) return cur;
    case (mode)
      0:       return x;
      1:       return (cur * 2) % 16;
      2:       return cur / 2;
      default: return (cur * 2) % 16 + cur / 8;
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic tick();
    bit cmp, mis;
    int nknown, ns;
    if (Rst) begin
      m_state = 0; m_exp = 0; m_known = 0; m_err = 0; m_fail = 0; m_ecnt = 0; m_ccnt = 0;
    end else begin
      cmp    = Arm && (m_state >= 2);
      mis    = cmp && (int'(DutY) != m_exp);
      nknown = (Arm && (m_known != 0 || DutRst || DutSet || (!DutHold && DutS == 2'd0))) ? 1 : 0;
      if (!Arm) ns = 0;
      else if (m_state == 0) ns = 1;
      else if (m_state == 1) ns = nknown ? 2 : 1;
      else if (m_state == 2) ns = mis ? 3 : 2;
      else ns = 3;
      m_err = mis ? 1 : 0;
      if (mis) begin m_fail = 1; m_ecnt = sat(m_ecnt + 1); end
      if (cmp) m_ccnt = sat(m_ccnt + 1);
      if (!Arm) m_fail = 0;
      m_exp   = next_reg(m_exp, DutRst, DutSet, DutHold, int'(DutS), int'(DutX));
      m_known = nknown;
      m_state = ns;
    end
    reg_y = next_reg(reg_y, DutRst, DutSet, DutHold, int'(DutS), int'(DutX));
    @(posedge Clk);
    #1;
    check_val("state",    32'(State),    32'(m_state));
    check_val("err",      32'(Err),      32'(m_err));
    check_val("fail",     32'(Fail),     32'(m_fail));
    check_val("errcnt",   32'(ErrCnt),   32'(m_ecnt));
    check_val("chkcnt",   32'(ChkCnt),   32'(m_ccnt));
    check_val("expected", 32'(Expected), 32'(m_exp));
  endtask

  // ymode: 0 = correct register output, 1 = inverted, 2 = forced zero
  task automatic cyc(input bit rst, input bit arm, input bit hold, input bit drst,
                     input bit dset, input int s, input int x, input int ymode);
    Rst = rst; Arm = arm; DutHold = hold; DutRst = drst; DutSet = dset;
    DutS = 2'(s); DutX = 4'(x);
    case (ymode)
      0:       DutY = 4'(reg_y);
      1:       DutY = 4'(reg_y ^ 15);
      default: DutY = 4'b0000;
    endcase
    tick();
  endtask

  initial begin
    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check_val("rst_state", 32'(State), 32'd0);

    // Arm, clear pulse, load 0011, track correctly
    cyc(0, 1, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 3, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    check_val("sync_check", 32'(State), 32'd2);
    check_val("sync_chk1",  32'(ChkCnt), 32'd1);
    check_val("sync_err",   32'(Err), 32'd0);

    // Load then shift left, shift right, rotate
    cyc(0, 1, 0, 0, 0, 0, 7, 0);
    check_val("load0111", 32'(Expected), 32'd7);
    cyc(0, 1, 0, 0, 0, 1, 7, 0);
    check_val("shl1110",  32'(Expected), 32'd14);
    cyc(0, 1, 0, 0, 0, 2, 11, 0);
    check_val("shr0111",  32'(Expected), 32'd7);
    cyc(0, 1, 0, 0, 0, 3, 15, 0);
    check_val("rotl1110", 32'(Expected), 32'd14);
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    check_val("modes_noerr", 32'(ErrCnt), 32'd0);

    // Hold across all modes, then a bad output
    for (int m = 0; m < 4; m++) begin
      cyc(0, 1, 1, 0, 0, m, int'($urandom_range(0, 15)), 0);
      check_val("hold_exp", 32'(Expected), 32'd14);
    end
    cyc(0, 1, 1, 0, 0, 0, 0, 2);
    check_val("hold_err",   32'(Err),   32'd1);
    check_val("hold_fail",  32'(Fail),  32'd1);
    check_val("hold_state", 32'(State), 32'd3);
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    check_val("err_pulse", 32'(Err), 32'd0);

    // Simultaneous clear and set
    cyc(0, 1, 0, 1, 1, 0, 9, 0);
    check_val("rst_over_set", 32'(Expected), 32'd0);

    // Saturation under sustained mismatches
    for (int i = 0; i < 300; i++) cyc(0, 1, 0, 0, 0, int'($urandom_range(0, 3)),
                                      int'($urandom_range(0, 15)), 1);
    check_val("errcnt_sat", 32'(ErrCnt), 32'd255);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0, 0, 0, 1);
    check_val("errcnt_hold", 32'(ErrCnt), 32'd255);
    check_val("chkcnt_hold", 32'(ChkCnt), 32'd255);

    // Reset while failed, with a mismatch presented on the same edge
    cyc(1, 1, 1, 0, 0, 0, 0, 1);
    check_val("rst_state2", 32'(State),  32'd0);
    check_val("rst_fail",   32'(Fail),   32'd0);
    check_val("rst_errcnt", 32'(ErrCnt), 32'd0);
    check_val("rst_chkcnt", 32'(ChkCnt), 32'd0);
    check_val("rst_err",    32'(Err),    32'd0);

    // Disarm returns to idle and clears the sticky flag
    cyc(0, 1, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 5, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 2);
    check_val("pre_disarm_fail", 32'(Fail), 32'd1);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    check_val("disarm_state", 32'(State), 32'd0);
    check_val("disarm_fail",  32'(Fail),  32'd0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) != 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 15) == 0), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multireg4bit_checker.md
MULTIREG4BIT_CHECKER -- requirements
Module: multireg4bit_checker

Interface
REQ-001 Clk input 1: single clock; all state updates on the rising edge.
REQ-002 Rst input 1: synchronous active-high reset of the checker only, sampled on the rising edge of Clk.
REQ-003 Arm input 1: 1 enables checking; 0 returns the checker to IDLE on the next edge.
REQ-004 DutHold, DutRst, DutSet input 1 each: copies of the register-under-test control inputs.
REQ-005 DutS input 2: copy of the register mode select.
REQ-006 DutX input 4: copy of the register parallel data input.
REQ-007 DutY input 4: register output being checked.
REQ-008 Err output 1: one-cycle pulse on each detected mismatch.
REQ-009 Fail output 1: sticky mismatch flag.
REQ-010 ErrCnt output 8: saturating count of mismatches.
REQ-011 ChkCnt output 8: saturating count of compared cycles.
REQ-012 Expected output 4: current model value, for debug.
REQ-013 State output 2: current FSM state encoding.

Function
REQ-014 The checker SHALL hold a 4-bit reference model Exp with a Known flag, both updated on every rising edge from the Dut* inputs sampled at that edge.
REQ-015 Model priority SHALL be DutRst (Exp=0000) > DutSet (Exp=1111) > DutHold (Exp unchanged) > DutS.
REQ-016 DutS=00 SHALL load DutX.
REQ-017 DutS=01 SHALL shift left, inserting 0 at bit 0.
REQ-018 DutS=10 SHALL shift right, inserting 0 at bit 3.
REQ-019 DutS=11 SHALL rotate left by 1.
REQ-020 Known SHALL set on DutRst, DutSet or DutS=00 with DutHold=0, and stay set until the checker is reset or leaves an armed state.
REQ-021 FSM states: IDLE=00, SYNC=01, CHECK=10, FAILED=11.
REQ-022 Transitions:
- IDLE->SYNC when Arm=1.
- SYNC->CHECK on the edge where Known becomes 1.
- CHECK->FAILED on a mismatch.
- Any state->IDLE when Arm=0.
REQ-023 In CHECK and FAILED, at each edge, DutY SHALL be compared against Exp as it stood before that edge, i.e. the DUT output one cycle after the update.
REQ-024 In IDLE and SYNC no comparison SHALL occur and Err SHALL stay 0.
REQ-025 On a mismatch, Err=1 for exactly the following cycle, ErrCnt SHALL increment, and Fail SHALL set.
REQ-026 Each comparison SHALL increment ChkCnt; both counters SHALL saturate at 255 and never wrap.
REQ-027 FAILED SHALL keep comparing and counting; Fail SHALL clear only on Rst or on a return to IDLE.
REQ-028 A DutRst, DutSet or load during CHECK SHALL update Exp normally with no loss of Known.
REQ-029 Simultaneous DutRst and DutSet SHALL resolve to DutRst.

Reset
REQ-030 On Rst=1 the following SHALL take effect at the next edge, overriding all other inputs: State=IDLE, Exp=0000, Known=0, Err=0, Fail=0, ErrCnt=0, ChkCnt=0.
REQ-031 Rst asserted mid-CHECK SHALL discard the in-flight comparison; no Err pulse is produced for that edge.

Structure
REQ-032 A shared package SHALL hold:
- the state encodings;
- the DutS mode constants LOAD=00, SHL=01, SHR=10, ROTL=11;
- the counter width 8.
REQ-033 The reference model SHALL be a separate sub-module, multireg4bit_model, with inputs for clock, control and data and outputs for Exp and Known; FSM, compare and counters stay in the top.

Verification
REQ-034 Arm=1, DutRst pulse, then DutS=00 with X=0011 and Y tracking correctly -> State reaches CHECK, Err=0, ChkCnt increments.
REQ-035 Expected after loads for DutS=01 with X=0111, then 10 with 1011, then 11 with 1111: Exp=1110 -> 0111 -> 1110; correct Y -> ErrCnt=0.
REQ-036 DutHold=1 with DutS cycling 00..11 -> Exp unchanged; Y changing to 0000 -> Err pulse, Fail=1, State=FAILED.
REQ-037 DutSet=1 and DutRst=1 in the same cycle -> Exp=0000.
REQ-038 Forced 300 consecutive mismatches -> ErrCnt=255, holds there.
REQ-039 Rst mid-FAILED -> next cycle State=IDLE, Fail=0, ErrCnt=0, ChkCnt=0, Err=0.
